timer_apb_ctrl: RTL and testbench
=================================

Name: timer_apb_ctrl

Overview:
- APB slave register controller that configures and sequences the timer datapath.
- Holds the control fields consumed by the prescaler/counter-enable logic: timer_en, div_en, div_val, halt_req.
- Issues load strobes to the counter.
- Reports halt_ack and counter value back to software.
- Sits between the APB interconnect and the timer core.

Parameters:
- WAIT_CYC, 1: wait states inserted in every APB access phase; legal 0..3.
- ADDR_W, 12: width of paddr; only paddr[ADDR_W-1:0] decoded.

Ports:
- clk  in  1  system clock, all logic posedge.
- rst_n  in  1  reset, asynchronous, active-low.
- psel  in  1  APB select.
- penable  in  1  APB enable; access phase.
- pwrite  in  1  1 = write, 0 = read.
- paddr  in  ADDR_W  byte address.
- pwdata  in  32  write data.
- pstrb  in  4  byte-lane write strobes.
- pready  out  1  transfer complete; registered.
- prdata  out  32  read data; 0 when pready=0.
- pslverr  out  1  error response; 0 when pready=0.
- timer_en  out  1  TCR[0].
- div_en  out  1  TCR[1].
- div_val  out  4  TCR[11:8].
- halt_req  out  1  THCSR[0].
- halt_ack  in  1  halt acknowledge from counter control.
- cnt_wr_lo  out  1  one-cycle load strobe, counter bits [31:0].
- cnt_wr_hi  out  1  one-cycle load strobe, counter bits [63:32].
- cnt_wdata  out  32  load data; valid with either strobe.
- cnt_lo  in  32  live counter [31:0].
- cnt_hi  in  32  live counter [63:32].

Behaviour:
- Reset values:
  - pready=0, prdata=0, pslverr=0.
  - timer_en=0, div_en=0, div_val=4'h1, halt_req=0.
  - cnt_wr_lo=0, cnt_wr_hi=0, cnt_wdata=0.
  - FSM in IDLE, wait counter 0.
- FSM states:
  - IDLE: on psel&penable&!pready, load wait counter = WAIT_CYC. Go WAIT if WAIT_CYC>0, else READY.
  - WAIT: decrement wait counter each cycle; at 0 go READY. psel=0 goes to IDLE with no commit (abort).
  - READY: pready=1 for exactly one cycle; write commits and read data present in this cycle; next state IDLE.
- Latency: pready rises WAIT_CYC+1 cycles after the first access-phase cycle. Back-to-back transfers need a new setup phase; no pipelining.
- Register map (byte offsets; unmapped offsets read 0, writes ignored, pslverr=0):
  - 0x00 TCR: [0] timer_en, [1] div_en, [11:8] div_val; other bits read 0.
  - 0x04 TDR0: read returns cnt_lo; write pulses cnt_wr_lo with cnt_wdata=pwdata.
  - 0x08 TDR1: read returns cnt_hi; write pulses cnt_wr_hi.
  - 0x0C THCSR: [0] halt_req RW; [1] halt_ack RO, a 2-flop-synchronised copy of the halt_ack input.
- TCR write rules:
  - New div_val > 4'h8: pslverr=1, whole TCR unchanged.
  - Current timer_en=1 and the write changes div_en or div_val: pslverr=1, whole TCR unchanged. A write that only clears timer_en, with identical div fields, is legal.
  - A write may set timer_en and change div fields together when current timer_en=0.
- Load strobes assert the cycle after READY for exactly one cycle. cnt_wdata holds its value until the next load.
- Simultaneous events:
  - Writes to THCSR take effect regardless of halt_ack.
  - TCR writes during halt follow the same rules as above.
- Reset mid-transfer: FSM returns to IDLE, no strobe, all registers reset.

Optional Feature:
- Macro: TIMER_APB_WSTRB_EN.
- Defined: only byte lanes with pstrb[n]=1 are written. TCR error checks use the merged new value. A TDR write with pstrb != 4'hF gives pslverr=1 and no strobe.
- Undefined: pstrb ignored; every write is full-word.

Test Plan:
- Reset, read TCR -> prdata=32'h0000_0100, pready after WAIT_CYC+1 cycles, pslverr=0.
- Write TCR=32'h0000_0303 with timer disabled -> timer_en=1, div_en=1, div_val=3. Then write 32'h0000_0503 -> pslverr=1, div_val stays 3.
- Write TCR div_val=4'h9 with timer disabled -> pslverr=1, TCR unchanged.
- Write TDR1=32'hDEAD_BEEF -> cnt_wr_hi high for exactly 1 cycle after READY, cnt_wdata=32'hDEAD_BEEF; cnt_wr_lo stays 0.
- Write THCSR=1 -> halt_req=1. Drive halt_ack=1, then read THCSR after 2 cycles -> prdata=32'h3.
- With WAIT_CYC=2, drop psel during WAIT -> no pready, TCR unchanged. Assert rst_n=0 mid-WAIT -> all outputs at reset values.

Source files
------------

// File: rtl/timer_apb_ctrl.sv
// rtl/timer_apb_ctrl.sv - APB register controller for the timer datapath
// Optional byte-lane write strobes: define TIMER_APB_WSTRB_EN.
module timer_apb_ctrl #(
  parameter int WAIT_CYC = 1,
  parameter int ADDR_W   = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [31:0]       pwdata,
  input  logic [3:0]        pstrb,
  output logic              pready,
  output logic [31:0]       prdata,
  output logic              pslverr,
  output logic              timer_en,
  output logic              div_en,
  output logic [3:0]        div_val,
  output logic              halt_req,
  input  logic              halt_ack,
  output logic              cnt_wr_lo,
  output logic              cnt_wr_hi,
  output logic [31:0]       cnt_wdata,
  input  logic [31:0]       cnt_lo,
  input  logic [31:0]       cnt_hi
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_READY} state_t;

  localparam logic [1:0] WAIT_INIT = 2'(WAIT_CYC);

  state_t      state;
  logic [1:0]  wcnt;
  logic        wr_lo_pend;
  logic        wr_hi_pend;
  logic        ack_meta;
  logic        ack_sync;

  logic        sel_tcr;
  logic        sel_tdr0;
  logic        sel_tdr1;
  logic        sel_thcsr;
  logic [31:0] tcr_cur;
  logic [31:0] thcsr_cur;
  logic [31:0] tcr_new;
  logic [31:0] thcsr_new;
  logic        tcr_err;
  logic        tdr_err;
  logic [31:0] rd_val;
  logic        go_ready;
  logic        unused_bits;

  assign sel_tcr   = (paddr == ADDR_W'(32'h0));
  assign sel_tdr0  = (paddr == ADDR_W'(32'h4));
  assign sel_tdr1  = (paddr == ADDR_W'(32'h8));
  assign sel_thcsr = (paddr == ADDR_W'(32'hC));

  assign tcr_cur   = {20'h0, div_val, 6'h0, div_en, timer_en};
  assign thcsr_cur = {30'h0, ack_sync, halt_req};

  // Merge write data with current register contents and decide on error responses
  always_comb begin
    tcr_new   = pwdata;
    thcsr_new = pwdata;
    tdr_err   = 1'b0;
`ifdef TIMER_APB_WSTRB_EN
    for (int i = 0; i < 4; i++) begin
      if (!pstrb[i]) begin
        tcr_new[i*8 +: 8]   = tcr_cur[i*8 +: 8];
        thcsr_new[i*8 +: 8] = thcsr_cur[i*8 +: 8];
      end
    end
    tdr_err = (pstrb != 4'hF);
`endif
    // A running timer may only be stopped; its divider settings are frozen.
    tcr_err = (tcr_new[11:8] > 4'h8) ||
              (timer_en && ((tcr_new[1] != div_en) || (tcr_new[11:8] != div_val)));
  end

  // Read multiplexer; unmapped offsets return zero
  always_comb begin
    rd_val = 32'h0;
    if (sel_tcr)   rd_val = tcr_cur;
    if (sel_tdr0)  rd_val = cnt_lo;
    if (sel_tdr1)  rd_val = cnt_hi;
    if (sel_thcsr) rd_val = thcsr_cur;
  end

  // Transfer completes on the edge that moves the FSM into READY
  always_comb begin
    go_ready = 1'b0;
    if (state == S_IDLE && psel && penable && !pready && WAIT_CYC == 0) go_ready = 1'b1;
    if (state == S_WAIT && psel && wcnt <= 2'd1)                         go_ready = 1'b1;
  end

  assign unused_bits = ^{tcr_new[31:12], tcr_new[7:2], thcsr_new[31:1], pstrb};

  // Two-flop synchroniser for the halt acknowledge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_meta <= 1'b0;
      ack_sync <= 1'b0;
    end else begin
      ack_meta <= halt_ack;
      ack_sync <= ack_meta;
    end
  end

  // Access FSM with registered bus response, register commit and load strobes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      wcnt       <= 2'd0;
      pready     <= 1'b0;
      prdata     <= 32'h0;
      pslverr    <= 1'b0;
      timer_en   <= 1'b0;
      div_en     <= 1'b0;
      div_val    <= 4'h1;
      halt_req   <= 1'b0;
      cnt_wr_lo  <= 1'b0;
      cnt_wr_hi  <= 1'b0;
      cnt_wdata  <= 32'h0;
      wr_lo_pend <= 1'b0;
      wr_hi_pend <= 1'b0;
    end else begin
      cnt_wr_lo <= 1'b0;
      cnt_wr_hi <= 1'b0;

      case (state)
        S_IDLE: begin
          if (psel && penable && !pready) begin
            wcnt  <= WAIT_INIT;
            state <= (WAIT_CYC == 0) ? S_READY : S_WAIT;
          end
        end
        S_WAIT: begin
          if (!psel) begin
            wcnt  <= 2'd0;
            state <= S_IDLE;
          end else if (wcnt <= 2'd1) begin
            wcnt  <= 2'd0;
            state <= S_READY;
          end else begin
            wcnt <= wcnt - 2'd1;
          end
        end
        S_READY: begin
          state      <= S_IDLE;
          pready     <= 1'b0;
          prdata     <= 32'h0;
          pslverr    <= 1'b0;
          cnt_wr_lo  <= wr_lo_pend;
          cnt_wr_hi  <= wr_hi_pend;
          wr_lo_pend <= 1'b0;
          wr_hi_pend <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase

      if (go_ready) begin
        pready <= 1'b1;
        if (!pwrite) begin
          prdata <= rd_val;
        end else if (sel_tcr) begin
          if (tcr_err) begin
            pslverr <= 1'b1;
          end else begin
            timer_en <= tcr_new[0];
            div_en   <= tcr_new[1];
            div_val  <= tcr_new[11:8];
          end
        end else if (sel_tdr0 || sel_tdr1) begin
          if (tdr_err) begin
            pslverr <= 1'b1;
          end else begin
            cnt_wdata  <= pwdata;
            wr_lo_pend <= sel_tdr0;
            wr_hi_pend <= sel_tdr1;
          end
        end else if (sel_thcsr) begin
          halt_req <= thcsr_new[0];
        end
      end
    end
  end

endmodule

// File: tb/tb_timer_apb_ctrl.sv
// tb/tb_timer_apb_ctrl.sv - self-checking bench for timer_apb_ctrl
module tb_timer_apb_ctrl;

  localparam int WAIT_CYC = 2;
  localparam int ADDR_W   = 12;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              psel, penable, pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [31:0]       pwdata;
  logic [3:0]        pstrb;
  logic              pready, pslverr;
  logic [31:0]       prdata;
  logic              timer_en, div_en, halt_req, halt_ack;
  logic [3:0]        div_val;
  logic              cnt_wr_lo, cnt_wr_hi;
  logic [31:0]       cnt_wdata, cnt_lo, cnt_hi;

  timer_apb_ctrl #(.WAIT_CYC(WAIT_CYC), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .pready(pready), .prdata(prdata),
    .pslverr(pslverr), .timer_en(timer_en), .div_en(div_en), .div_val(div_val),
    .halt_req(halt_req), .halt_ack(halt_ack), .cnt_wr_lo(cnt_wr_lo), .cnt_wr_hi(cnt_wr_hi),
    .cnt_wdata(cnt_wdata), .cnt_lo(cnt_lo), .cnt_hi(cnt_hi)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } resp_t;

  typedef struct {
    logic        wr;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
    logic        te;
    logic        de;
    logic [3:0]  dv;
  } vec_t;

  resp_t sb_q[$];
  vec_t  vecs[15];
  int    checks   = 0;
  int    failures = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check32({tag, " pready"},    32'(pready),    32'h0);
    check32({tag, " prdata"},    prdata,         32'h0);
    check32({tag, " pslverr"},   32'(pslverr),   32'h0);
    check32({tag, " timer_en"},  32'(timer_en),  32'h0);
    check32({tag, " div_en"},    32'(div_en),    32'h0);
    check32({tag, " div_val"},   32'(div_val),   32'h1);
    check32({tag, " halt_req"},  32'(halt_req),  32'h0);
    check32({tag, " cnt_wr_lo"}, 32'(cnt_wr_lo), 32'h0);
    check32({tag, " cnt_wr_hi"}, 32'(cnt_wr_hi), 32'h0);
    check32({tag, " cnt_wdata"}, cnt_wdata,      32'h0);
  endtask

  task automatic check_tcr(input string tag, input logic te, input logic de, input logic [3:0] dv);
    check32({tag, " timer_en"}, 32'(timer_en), 32'(te));
    check32({tag, " div_en"},   32'(div_en),   32'(de));
    check32({tag, " div_val"},  32'(div_val),  32'(dv));
  endtask

  // Full APB transfer; expected response queued at access phase, compared when pready appears
  task automatic apb_xfer(input string tag, input logic wr, input logic [11:0] addr,
                          input logic [31:0] wdata, input logic [31:0] exp_rdata, input logic exp_err);
    resp_t r;
    resp_t e;
    int    lat;
    bit    done;
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wdata; pstrb = 4'hF;
    @(posedge clk); #1;
    penable = 1'b1;
    r.rdata = exp_rdata;
    r.err   = exp_err;
    sb_q.push_back(r);
    lat  = 0;
    done = 1'b0;
    while (!done && lat < 20) begin
      @(posedge clk); lat++;
      @(negedge clk);
      if (pready) done = 1'b1;
    end
    e = sb_q.pop_front();
    if (!done) begin
      checks++; failures++;
      $display("FAIL %s timeout: pready never seen, required within 20 cycles", tag);
    end else begin
      check32({tag, " latency"}, 32'(lat),     32'(WAIT_CYC + 1));
      check32({tag, " prdata"},  prdata,       e.rdata);
      check32({tag, " pslverr"}, 32'(pslverr), 32'(e.err));
    end
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  int seen;

  initial begin
    vecs[0]  = '{1'b0, 12'h000, 32'h0,         32'h0000_0100, 1'b0, 1'b0, 1'b0, 4'h1};
    vecs[1]  = '{1'b1, 12'h000, 32'h0000_0303, 32'h0,         1'b0, 1'b1, 1'b1, 4'h3};
    vecs[2]  = '{1'b1, 12'h000, 32'h0000_0503, 32'h0,         1'b1, 1'b1, 1'b1, 4'h3};
    vecs[3]  = '{1'b0, 12'h000, 32'h0,         32'h0000_0303, 1'b0, 1'b1, 1'b1, 4'h3};
    vecs[4]  = '{1'b1, 12'h000, 32'h0000_0302, 32'h0,         1'b0, 1'b0, 1'b1, 4'h3};
    vecs[5]  = '{1'b1, 12'h000, 32'h0000_0900, 32'h0,         1'b1, 1'b0, 1'b1, 4'h3};
    vecs[6]  = '{1'b1, 12'h000, 32'h0000_0801, 32'h0,         1'b0, 1'b1, 1'b0, 4'h8};
    vecs[7]  = '{1'b1, 12'h000, 32'h0000_0801, 32'h0,         1'b0, 1'b1, 1'b0, 4'h8};
    vecs[8]  = '{1'b0, 12'h010, 32'h0,         32'h0,         1'b0, 1'b1, 1'b0, 4'h8};
    vecs[9]  = '{1'b1, 12'h010, 32'hFFFF_FFFF, 32'h0,         1'b0, 1'b1, 1'b0, 4'h8};
    vecs[10] = '{1'b1, 12'h000, 32'h0000_0800, 32'h0,         1'b0, 1'b0, 1'b0, 4'h8};
    vecs[11] = '{1'b0, 12'h004, 32'h0,         32'h1234_5678, 1'b0, 1'b0, 1'b0, 4'h8};
    vecs[12] = '{1'b0, 12'h008, 32'h0,         32'h9ABC_DEF0, 1'b0, 1'b0, 1'b0, 4'h8};
    vecs[13] = '{1'b1, 12'h000, 32'hFFFF_F1FE, 32'h0,         1'b0, 1'b0, 1'b1, 4'h1};
    vecs[14] = '{1'b0, 12'h002, 32'h0,         32'h0,         1'b0, 1'b0, 1'b1, 4'h1};

    rst_n = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0;
    pwdata = 32'h0; pstrb = 4'hF; halt_ack = 1'b0;
    cnt_lo = 32'h1234_5678; cnt_hi = 32'h9ABC_DEF0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_vals("reset");
    @(posedge clk); #1 rst_n = 1'b1;

    for (int i = 0; i < 15; i++) begin
      apb_xfer($sformatf("vec%0d", i), vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].rdata, vecs[i].err);
      check_tcr($sformatf("vec%0d", i), vecs[i].te, vecs[i].de, vecs[i].dv);
    end
    apb_xfer("tcr_rb", 1'b0, 12'h000, 32'h0, 32'h0000_0102, 1'b0);

    // TDR1 load strobe
    apb_xfer("tdr1", 1'b1, 12'h008, 32'hDEAD_BEEF, 32'h0, 1'b0);
    @(negedge clk);
    check32("tdr1 strobe hi",  32'(cnt_wr_hi), 32'h1);
    check32("tdr1 strobe lo",  32'(cnt_wr_lo), 32'h0);
    check32("tdr1 wdata",      cnt_wdata,      32'hDEAD_BEEF);
    check32("tdr1 pready low", 32'(pready),    32'h0);
    @(negedge clk);
    check32("tdr1 strobe hi end", 32'(cnt_wr_hi), 32'h0);
    check32("tdr1 strobe lo end", 32'(cnt_wr_lo), 32'h0);
    check32("tdr1 wdata hold",    cnt_wdata,      32'hDEAD_BEEF);

    // TDR0 load strobe
    apb_xfer("tdr0", 1'b1, 12'h004, 32'h0BAD_F00D, 32'h0, 1'b0);
    @(negedge clk);
    check32("tdr0 strobe lo", 32'(cnt_wr_lo), 32'h1);
    check32("tdr0 strobe hi", 32'(cnt_wr_hi), 32'h0);
    check32("tdr0 wdata",     cnt_wdata,      32'h0BAD_F00D);
    @(negedge clk);
    check32("tdr0 strobe lo end", 32'(cnt_wr_lo), 32'h0);

    // Halt request and synchronised acknowledge
    apb_xfer("thcsr set", 1'b1, 12'h00C, 32'h1, 32'h0, 1'b0);
    check32("halt_req set", 32'(halt_req), 32'h1);
    halt_ack = 1'b1;
    repeat (2) @(posedge clk);
    apb_xfer("thcsr rd", 1'b0, 12'h00C, 32'h0, 32'h3, 1'b0);
    apb_xfer("thcsr clr", 1'b1, 12'h00C, 32'h0, 32'h0, 1'b0);
    check32("halt_req clr", 32'(halt_req), 32'h0);
    apb_xfer("thcsr rd2", 1'b0, 12'h00C, 32'h0, 32'h2, 1'b0);
    halt_ack = 1'b0;

    // Abort during WAIT: psel drops after the first access cycle
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 12'h000; pwdata = 32'h0000_0305;
    @(posedge clk); #1 penable = 1'b1;
    @(posedge clk); #1 begin psel = 1'b0; penable = 1'b0; end
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (pready) seen++;
    end
    check32("abort no pready", 32'(seen), 32'h0);
    check_tcr("abort", 1'b0, 1'b1, 4'h1);
    apb_xfer("abort rb", 1'b0, 12'h000, 32'h0, 32'h0000_0102, 1'b0);

    // Reset in the middle of a TDR0 write
    apb_xfer("pre rst tcr", 1'b1, 12'h000, 32'h0000_0303, 32'h0, 1'b0);
    apb_xfer("pre rst thcsr", 1'b1, 12'h00C, 32'h1, 32'h0, 1'b0);
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 12'h004; pwdata = 32'h5555_AAAA;
    @(posedge clk); #1 penable = 1'b1;
    @(posedge clk); #1 rst_n = 1'b0;
    @(negedge clk);
    check_reset_vals("midrst");
    psel = 1'b0; penable = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (cnt_wr_lo || cnt_wr_hi || pready) seen++;
    end
    check32("midrst no strobe", 32'(seen), 32'h0);
    apb_xfer("post rst tcr", 1'b0, 12'h000, 32'h0, 32'h0000_0100, 1'b0);

    check32("scoreboard empty", 32'(sb_q.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
